serial_subtractor_mux: RTL

- Multi-cycle, parametrised N-bit subtractor that computes diff = a - b - bin.
- Built from a mux-select full-subtractor cell, replicated BPC times and iterated over WIDTH/BPC cycles.
- Adds a start/busy/done handshake, borrow chaining across cycles, and signed-overflow and zero flags.
- Sits beside the single-bit subtractor cells as the arithmetic datapath for small control units where area matters more than latency.

---
 rtl/serial_subtractor_mux_pkg.sv | 23 ++
 rtl/serial_subtractor_mux_fs_mux_cell.sv | 23 ++
 rtl/serial_subtractor_mux.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_subtractor_mux_pkg.sv
// Shared definitions for the serial subtractor: controller states and
// sizing helpers for the slice counter.
package serial_subtractor_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of cycles needed to walk an operand BPC bits at a time
  function automatic int calcNslice(input int width, input int bpc);
    return width / bpc;
  endfunction

  // Counter width for NSLICE slices, never narrower than one bit
  function automatic int calcCntWidth(input int nslice);
    int w;
    w = $clog2(nslice);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_subtractor_mux_fs_mux_cell.sv
// One-bit full subtractor built as a 4:1 mux selected by the operand bits.
module fs_mux_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bi_i,
  output logic d_o,
  output logic bo_o
);

  // Operand pair picks the difference and borrow straight from borrow-in
  always_comb begin
    d_o  = bi_i;
    bo_o = bi_i;
    case ({a_i, b_i})
      2'b00: begin d_o = bi_i;  bo_o = bi_i; end
      2'b01: begin d_o = ~bi_i; bo_o = 1'b1; end
      2'b10: begin d_o = ~bi_i; bo_o = 1'b0; end
      2'b11: begin d_o = bi_i;  bo_o = bi_i; end
      default: begin d_o = bi_i; bo_o = bi_i; end
    endcase
  end

endmodule

// File: rtl/serial_subtractor_mux.sv
// Multi-cycle subtractor: diff = a - b - bin, BPC bits per clock, with a
// start/busy/done handshake and registered borrow, overflow and zero flags.
module serial_subtractor_mux
  import serial_subtractor_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NSLICE = calcNslice(WIDTH, BPC);
  localparam int CW     = calcCntWidth(NSLICE);

  // A slice width that does not tile the operand is a configuration error
  if ((WIDTH % BPC) != 0) begin : g_bad_bpc
    $error("serial_subtractor_mux: BPC must divide WIDTH evenly");
  end

  state_e           state_q;
  logic [WIDTH-1:0] aSh_q, bSh_q, dSh_q, dSh_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q;
  logic             aMsb_q, bMsb_q;
  logic             busy_q, done_q, bout_q, ovf_q, zero_q;
  logic [WIDTH-1:0] diff_q;

  logic [BPC:0]         borrowChain;
  logic [BPC-1:0]       cellDiff;
  logic [WIDTH+BPC-1:0] dCat;

  assign borrowChain[0] = brw_q;

  for (genvar i = 0; i < BPC; i++) begin : g_cell
    fs_mux_cell u_cell (
      .a_i  (aSh_q[i]),
      .b_i  (bSh_q[i]),
      .bi_i (borrowChain[i]),
      .d_o  (cellDiff[i]),
      .bo_o (borrowChain[i+1])
    );
  end

  // New result bits enter at the MSB end so the LSB slice lands at bit 0
  assign dCat  = {cellDiff, dSh_q};
  assign dSh_d = dCat[WIDTH+BPC-1:BPC];
  assign brw_d = borrowChain[BPC];

  // Controller, datapath registers and registered outputs in one process
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      dSh_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      aMsb_q  <= 1'b0;
      bMsb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            aSh_q   <= a_i;
            bSh_q   <= b_i;
            brw_q   <= bin_i;
            aMsb_q  <= a_i[WIDTH-1];
            bMsb_q  <= b_i[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          aSh_q <= aSh_q >> BPC;
          bSh_q <= bSh_q >> BPC;
          dSh_q <= dSh_d;
          brw_q <= brw_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(NSLICE - 1)) begin
            diff_q  <= dSh_d;
            bout_q  <= brw_d;
            ovf_q   <= (aMsb_q ^ bMsb_q) & (dSh_d[WIDTH-1] ^ aMsb_q);
            zero_q  <= (dSh_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign bout_o = bout_q;
  assign ovf_o  = ovf_q;
  assign zero_o = zero_q;

endmodule
